// File: rtl/sonar_fb_pkg.sv
// Shared constants and state encoding for the sonar framebuffer writer.
// Geometry defaults describe a 640x480 one-bit-per-pixel display.
package sonar_fb_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_DEPTH  = 307200;
  localparam int FB_ADDR_W = 19;
  localparam int FB_X_W    = 10;
  localparam int FB_Y_W    = 9;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ERASE = 2'd2,
    ST_PLOT  = 2'd3
  } fb_state_t;

endpackage

// File: rtl/fb_addr_stepper.sv
// Running framebuffer address: walks linearly for a full clear, or down one
// column (stride WIDTH) with a row counter for a bearing erase.
module fb_addr_stepper
  import sonar_fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 load,
  input  logic [FB_ADDR_W-1:0] load_addr,
  input  logic                 load_wide,
  input  logic                 step,
  output logic [FB_ADDR_W-1:0] addr,
  output logic [FB_Y_W-1:0]    row,
  output logic                 last
);

  localparam logic [FB_ADDR_W-1:0] ROW_STRIDE = FB_ADDR_W'(WIDTH);
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR  = FB_ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [FB_Y_W-1:0]    LAST_ROW   = FB_Y_W'(HEIGHT - 1);

  logic [FB_ADDR_W-1:0] addr_reg;
  logic [FB_Y_W-1:0]    row_reg;
  logic                 wide_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      addr_reg <= '0;
      row_reg  <= '0;
      wide_reg <= 1'b0;
    end else if (load) begin
      addr_reg <= load_addr;
      row_reg  <= '0;
      wide_reg <= load_wide;
    end else if (step) begin
      addr_reg <= addr_reg + (wide_reg ? ROW_STRIDE : FB_ADDR_W'(1));
      if (wide_reg) begin
        row_reg <= row_reg + FB_Y_W'(1);
      end
    end
  end

  assign addr = addr_reg;
  assign row  = row_reg;
  // Column walks end on the bottom row; linear walks end on the final pixel.
  assign last = wide_reg ? (row_reg == LAST_ROW) : (addr_reg == LAST_ADDR);

endmodule

// File: rtl/sonar_fb_writer.sv
// Sonar sweep renderer: clears the screen, then for each sample erases its
// bearing column and lights the echo pixel, one framebuffer write per cycle.
module sonar_fb_writer #(
  parameter int FB_WIDTH  = sonar_fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = sonar_fb_pkg::FB_HEIGHT
) (
  input  logic                               CLK100MHZ,
  input  logic                               reset,
  input  logic                               sample_valid,
  input  logic [sonar_fb_pkg::FB_X_W-1:0]    sample_x,
  input  logic [sonar_fb_pkg::FB_Y_W-1:0]    sample_y,
  output logic                               sample_ready,
  input  logic                               clear_req,
  output logic                               wr_en,
  output logic [sonar_fb_pkg::FB_ADDR_W-1:0] wr_addr,
  output logic                               wr_data,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);
  import sonar_fb_pkg::*;

  fb_state_t            state_reg;
  logic                 clear_pending_reg;
  logic                 wr_en_reg;
  logic                 wr_data_reg;
  logic                 done_reg;
  logic                 err_reg;
  logic [FB_Y_W-1:0]    y_reg;
  logic [FB_ADDR_W-1:0] plot_addr_reg;

  logic                 step_load;
  logic [FB_ADDR_W-1:0] step_load_addr;
  logic                 step_load_wide;
  logic                 step_step;
  logic [FB_ADDR_W-1:0] step_addr;
  logic [FB_Y_W-1:0]    step_row;
  logic                 step_last;

  logic accept;
  logic x_in_range;
  logic y_in_range;

  assign sample_ready = (state_reg == ST_IDLE) & ~clear_req & ~clear_pending_reg;
  assign accept       = sample_valid & sample_ready;
  assign x_in_range   = int'(sample_x) < FB_WIDTH;
  assign y_in_range   = int'(y_reg) < FB_HEIGHT;

  fb_addr_stepper #(
    .WIDTH  (FB_WIDTH),
    .HEIGHT (FB_HEIGHT)
  ) u_stepper (
    .clk       (CLK100MHZ),
    .srst      (reset),
    .load      (step_load),
    .load_addr (step_load_addr),
    .load_wide (step_load_wide),
    .step      (step_step),
    .addr      (step_addr),
    .row       (step_row),
    .last      (step_last)
  );

  // The stepper always holds the address of the write currently on the bus.
  always_comb begin
    step_load      = 1'b0;
    step_load_addr = '0;
    step_load_wide = 1'b0;
    step_step      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clear_req | clear_pending_reg) begin
          step_load = 1'b1;
        end else if (accept & x_in_range) begin
          step_load      = 1'b1;
          step_load_addr = FB_ADDR_W'(sample_x);
          step_load_wide = 1'b1;
        end
      end
      ST_CLEAR, ST_ERASE: step_step = wr_en_reg & ~step_last;
      default: ;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_reg         <= ST_CLEAR;
      clear_pending_reg <= 1'b0;
      wr_en_reg         <= 1'b0;
      wr_data_reg       <= 1'b0;
      done_reg          <= 1'b0;
      err_reg           <= 1'b0;
      y_reg             <= '0;
      plot_addr_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_CLEAR: begin
          clear_pending_reg <= 1'b0;
          // First cycle out of reset only arms the write strobe at address 0.
          if (!wr_en_reg) begin
            wr_en_reg <= 1'b1;
          end else if (step_last) begin
            state_reg <= ST_IDLE;
            wr_en_reg <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clear_req | clear_pending_reg) begin
            state_reg         <= ST_CLEAR;
            clear_pending_reg <= 1'b0;
            wr_en_reg         <= 1'b1;
            wr_data_reg       <= 1'b0;
          end else if (accept) begin
            if (x_in_range) begin
              state_reg   <= ST_ERASE;
              y_reg       <= sample_y;
              wr_en_reg   <= 1'b1;
              wr_data_reg <= 1'b0;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_ERASE: begin
          if (clear_req) clear_pending_reg <= 1'b1;
          // Capture the echo address as the column walk passes it.
          if (step_row == y_reg) plot_addr_reg <= step_addr;
          if (step_last) begin
            if (y_in_range) begin
              state_reg   <= ST_PLOT;
              wr_data_reg <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
              wr_en_reg <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        ST_PLOT: begin
          if (clear_req) clear_pending_reg <= 1'b1;
          state_reg   <= ST_IDLE;
          wr_en_reg   <= 1'b0;
          wr_data_reg <= 1'b0;
          done_reg    <= 1'b1;
        end
        default: state_reg <= ST_CLEAR;
      endcase
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_data = wr_data_reg;
  assign wr_addr = !wr_en_reg ? '0 : ((state_reg == ST_PLOT) ? plot_addr_reg : step_addr);
  assign busy    = state_reg != ST_IDLE;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule

// File: doc/sonar_fb_writer.md
SONAR_FB_WRITER -- requirements
Module: sonar_fb_writer

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 640, meaning framebuffer columns.
REQ-002 SHALL have parameter FB_HEIGHT, default 480, meaning framebuffer rows.
REQ-003 SHALL have port CLK100MHZ  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sample_valid  input  1  sonar sample offered.
REQ-006 SHALL have port sample_x  input  10  column (bearing) of sample.
REQ-007 SHALL have port sample_y  input  9  row (range) of echo; value >= FB_HEIGHT means no echo.
REQ-008 SHALL have port sample_ready  output  1  block accepts a sample this cycle.
REQ-009 SHALL have port clear_req  input  1  request full-screen clear.
REQ-010 SHALL have port wr_en  output  1  framebuffer write strobe.
REQ-011 SHALL have port wr_addr  output  19  framebuffer address, x + FB_WIDTH*y.
REQ-012 SHALL have port wr_data  output  1  pixel value (1 = lit).
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a sample is fully drawn.
REQ-015 SHALL have port err  output  1  one-cycle pulse when a sample is dropped.

Function
REQ-016 SHALL implement states CLEAR, IDLE, ERASE, PLOT.
REQ-017 CLEAR SHALL write wr_data=0 to addresses 0..FB_WIDTH*FB_HEIGHT-1, one per cycle, ascending, then go to IDLE.
REQ-018 sample_ready SHALL equal (state==IDLE) & ~clear_req & ~clear_pending.
REQ-019 A handshake (sample_valid & sample_ready) with sample_x < FB_WIDTH SHALL latch x,y and enter ERASE next cycle.
REQ-020 A handshake with sample_x >= FB_WIDTH SHALL produce no writes, pulse err next cycle, and stay in IDLE.
REQ-021 ERASE SHALL write wr_data=0 to addresses x + FB_WIDTH*r for r = 0..FB_HEIGHT-1, one per cycle, ascending r.
REQ-022 ERASE addresses SHALL be generated by adding FB_WIDTH to a running address each cycle; no multiplier.
REQ-023 After the last ERASE write, if latched y < FB_HEIGHT, state SHALL be PLOT for one cycle, writing wr_data=1 at x + FB_WIDTH*y.
REQ-024 If latched y >= FB_HEIGHT, PLOT SHALL be skipped.
REQ-025 done SHALL pulse in the cycle after the final write of an accepted in-range sample, as state returns to IDLE.
REQ-026 clear_req in IDLE SHALL enter CLEAR next cycle; clear_req wins over a simultaneous sample_valid.
REQ-027 clear_req during ERASE/PLOT SHALL set clear_pending; the current sample completes including done, then CLEAR starts.
REQ-028 clear_req during CLEAR SHALL be ignored; the clear does not restart.
REQ-029 wr_en SHALL be high exactly on cycles a write is issued; wr_addr and wr_data are don't-care otherwise, and SHALL be driven to 0 when idle.
REQ-030 Every write sequence SHALL issue one write per cycle with no gaps.

Reset
REQ-031 Reset SHALL force state CLEAR, write address 0, clear_pending=0, wr_en=0, done=0, err=0, busy=1, sample_ready=0.
REQ-032 Reset asserted mid-operation SHALL abandon the operation; the clear SHALL restart at address 0 on the first cycle after reset deasserts.

Structure
REQ-033 Shared package sonar_fb_pkg SHALL hold FB_WIDTH, FB_HEIGHT, FB_DEPTH=307200, FB_ADDR_W=19 and the state encoding.
REQ-034 One sub-module, fb_addr_stepper, SHALL hold the running address and row counter (load, step by 1 or by FB_WIDTH, last-flag).

Verification
REQ-035 Reset released -> 307200 writes of 0, addr 0..307199; sample_ready rises the cycle after the write to 307199.
REQ-036 Sample x=5, y=10 -> 480 zero writes at 5, 645, ..., 306565; then a write of 1 at 6405; done one cycle later.
REQ-037 Sample x=639, y=479 -> last erase at 307199, then a write of 1 at 307199.
REQ-038 Sample x=640 -> no wr_en, err pulse, sample_ready stays high.
REQ-039 Sample x=3, y=480 -> 480 zero writes at column 3, no PLOT write, done pulses.
REQ-040 clear_req at erase row 100 -> column and plot complete, done pulses, then a full 307200-write clear starts; reset at clear address 1000 -> clear restarts at 0.
